// File: rtl/mult_sched_pkg.sv
// Shared constants and types for the round-robin multiplier scheduler.
// Operand width, result width and the requester-index width helper live here.
package mult_sched_pkg;

  localparam int NREQ_DEFAULT = 4;
  localparam int OP_W         = 8;
  localparam int RESP_W       = 16;

  // Index width for n requesters; never narrower than one bit.
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef struct packed {
    logic [OP_W-1:0] a;
    logic [OP_W-1:0] b;
  } operand_t;

endpackage

// File: rtl/Zero_ME_7_8.sv
// Shared 8x8 unsigned multiplier, purely combinational.
// CLK only clocks the embedded sanity property on zero operands.
module Zero_ME_7_8
  import mult_sched_pkg::*;
(
  input  logic              CLK,
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  output logic [RESP_W-1:0] p
);

  assign p = {8'd0, a} * {8'd0, b};

  zero_operand_gives_zero: assert property (
    @(posedge CLK) ((a == '0) || (b == '0)) |-> (p == '0)
  );

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the search starts at ptr, the first asserted request wins.
// ptr moves past the winner only when the caller strobes update (a real transfer).
module rr_arbiter
  import mult_sched_pkg::*;
#(
  parameter  int NREQ = NREQ_DEFAULT,
  localparam int IDW  = id_w(NREQ)
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [NREQ-1:0] req,
  input  logic            update,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_id,
  output logic [IDW-1:0]  ptr
);

  logic           found;
  logic [IDW-1:0] idx;

  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = IDW'((int'(ptr) + k) % NREQ);
      if (!found && req[idx]) begin
        found       = 1'b1;
        grant[idx]  = 1'b1;
        grant_id    = idx;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      ptr <= '0;
    end else if (update) begin
      ptr <= (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + IDW'(1);
    end
  end

endmodule

// File: rtl/mult_rr_scheduler.sv
// NREQ requesters share one multiplier through a 2-stage pipeline (S1 operands,
// S2 result), granted round-robin, with a wrapping count of delivered results.
module mult_rr_scheduler
  import mult_sched_pkg::*;
#(
  parameter  int NREQ        = NREQ_DEFAULT,
  parameter  int ZERO_BYPASS = 1,
  localparam int IDW         = id_w(NREQ)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [OP_W*NREQ-1:0] req_a,
  input  logic [OP_W*NREQ-1:0] req_b,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [IDW-1:0]       resp_id,
  output logic [RESP_W-1:0]    resp_data,
  output logic [15:0]          ops_count
);

  // Handshakes: a transfer happens on a rising CLK edge where valid and ready
  // are both high. Producers hold valid and data until then; ready may follow
  // valid combinationally, never the reverse.

  logic              s1_v;
  logic [IDW-1:0]    s1_id;
  operand_t          s1_op;
  operand_t          sel_op;
  logic              s1_ready;
  logic              s2_ready;
  logic [NREQ-1:0]   grant;
  logic [IDW-1:0]    grant_id;
  logic [IDW-1:0]    arb_ptr;
  logic              transfer;
  logic [RESP_W-1:0] mult_p;
  logic [RESP_W-1:0] prod;

  assign s2_ready  = !resp_valid || resp_ready;
  assign s1_ready  = !s1_v || s2_ready;
  assign req_ready = grant & {NREQ{s1_ready & ~RST}};
  assign transfer  = |(req_valid & req_ready);

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .CLK      (CLK),
    .RST      (RST),
    .req      (req_valid),
    .update   (transfer),
    .grant    (grant),
    .grant_id (grant_id),
    .ptr      (arb_ptr)
  );

  always_comb begin
    sel_op   = '0;
    sel_op.a = req_a[OP_W*int'(grant_id) +: OP_W];
    sel_op.b = req_b[OP_W*int'(grant_id) +: OP_W];
  end

  // S1 refills in the same cycle it drains into S2.
  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_v  <= 1'b0;
      s1_id <= '0;
      s1_op <= '0;
    end else if (s1_ready) begin
      s1_v <= transfer;
      if (transfer) begin
        s1_id <= grant_id;
        s1_op <= sel_op;
      end
    end
  end

  Zero_ME_7_8 u_mult (
    .CLK (CLK),
    .a   (s1_op.a),
    .b   (s1_op.b),
    .p   (mult_p)
  );

  always_comb begin
    prod = mult_p;
    if ((ZERO_BYPASS != 0) && ((s1_op.a == '0) || (s1_op.b == '0))) begin
      prod = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_data  <= '0;
    end else if (s2_ready) begin
      resp_valid <= s1_v;
      if (s1_v) begin
        resp_id   <= s1_id;
        resp_data <= prod;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      ops_count <= '0;
    end else if (resp_valid && resp_ready) begin
      ops_count <= ops_count + 16'd1;
    end
  end

  ready_is_onehot0: assert property (@(posedge CLK) $onehot0(req_ready));
  ptr_in_range: assert property (@(posedge CLK) int'(arb_ptr) < NREQ);

endmodule

// File: tb/tb_mult_rr_scheduler.sv
// Bench for mult_rr_scheduler: directed phases with randomized operands, checked
// against a capacity-2 in-order queue model with a round-robin pointer.
module tb_mult_rr_scheduler;

  localparam int NREQ  = 4;
  localparam int IDW   = 2;
  localparam int EXP_W = 56;

  logic              CLK = 1'b0;
  logic              RST;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [8*NREQ-1:0] req_a;
  logic [8*NREQ-1:0] req_b;
  logic              resp_valid;
  logic              resp_ready;
  logic [IDW-1:0]    resp_id;
  logic [15:0]       resp_data;
  logic [15:0]       ops_count;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;
  int cyc     = 0;
  int ptr_m   = 0;
  int ops_m   = 0;

  // Entry: {accept_cycle[31:0], id[7:0], product[15:0]}, oldest first.
  logic [EXP_W-1:0] exp_q[$];
  int               gnt_log[$];

  // ---------------- clock ----------------
  always #5 CLK = ~CLK;

  mult_rr_scheduler #(
    .NREQ        (NREQ),
    .ZERO_BYPASS (1)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_data  (resp_data),
    .ops_count  (ops_count)
  );

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] rand_byte();
    if ($urandom_range(0, 3) == 0) return 8'h00;
    return 8'($urandom_range(0, 255));
  endfunction

  // ---------------- drivers ----------------
  task automatic randomize_ops();
    for (int i = 0; i < NREQ; i++) begin
      req_a[8*i +: 8] = rand_byte();
      req_b[8*i +: 8] = rand_byte();
    end
  endtask

  // One clock: predict, compare (when full), advance across the edge, update model.
  task automatic step(input bit full);
    logic [NREQ-1:0]  exp_ready;
    logic [EXP_W-1:0] head;
    logic [7:0]       a_w;
    logic [7:0]       b_w;
    logic [15:0]      prod;
    int               win;
    bit               cap;
    bit               exp_rv;
    #1;
    win = -1;
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (ptr_m + k) % NREQ;
      if (win < 0 && req_valid[idx]) win = idx;
    end
    cap       = (exp_q.size() < 2) || resp_ready;
    exp_ready = '0;
    if (!RST && cap && win >= 0) exp_ready = NREQ'(1) << win;
    head   = (exp_q.size() > 0) ? exp_q[0] : '0;
    exp_rv = (exp_q.size() > 0) && (cyc - int'(head[55:24]) >= 1);
    if (full) begin
      check("req_ready", 32'(req_ready), 32'(exp_ready));
      check("resp_valid", 32'(resp_valid), 32'(exp_rv));
      if (exp_rv) begin
        check("resp_id", 32'(resp_id), 32'(head[23:16]));
        check("resp_data", 32'(resp_data), 32'(head[15:0]));
      end
      check("ops_count", 32'(ops_count), 32'(ops_m & 32'hFFFF));
    end
    if (!RST) begin
      for (int i = 0; i < NREQ; i++) if (req_ready[i]) gnt_log.push_back(i);
    end
    @(posedge CLK);
    cyc++;
    if (RST) begin
      exp_q.delete();
      ptr_m = 0;
      ops_m = 0;
    end else begin
      if (exp_rv && resp_ready) begin
        void'(exp_q.pop_front());
        ops_m++;
      end
      if (exp_ready != '0) begin
        a_w  = 8'(req_a >> (8 * win));
        b_w  = 8'(req_b >> (8 * win));
        prod = 16'(a_w) * 16'(b_w);
        exp_q.push_back({32'(cyc), 8'(win), prod});
        ptr_m = (win + 1) % NREQ;
      end
    end
    @(negedge CLK);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    step(1);
    RST = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int exp_rr[5];
    int exp_sp[4];
    int guard;
    exp_rr = '{0, 1, 2, 3, 0};
    exp_sp = '{3, 1, 3, 1};
    RST        = 1'b1;
    req_valid  = '0;
    req_a      = '0;
    req_b      = '0;
    resp_ready = 1'b1;

    // Reset: first edge unchecked (outputs unknown before it), then checked.
    step(0);
    req_valid = 4'b1111;
    randomize_ops();
    step(1);
    check("reset_resp_valid", 32'(resp_valid), 32'd0);
    check("reset_ops_count", 32'(ops_count), 32'd0);
    RST = 1'b0;

    // Single request with a zero multiplicand.
    req_valid = 4'b0001;
    req_a     = '0;
    req_b     = 32'h0000_0055;
    step(1);
    req_valid = '0;
    step(1);
    check("single_resp_valid", 32'(resp_valid), 32'd1);
    check("single_resp_data", 32'(resp_data), 32'h0000);
    step(1);
    step(1);
    check("single_ops_count", 32'(ops_count), 32'd1);

    // All requesters continuously valid from reset.
    do_reset();
    gnt_log.delete();
    req_valid = 4'b1111;
    for (int i = 0; i < 12; i++) begin
      randomize_ops();
      step(1);
    end
    for (int i = 0; i < 5; i++)
      check("rr_grant_seq", (i < gnt_log.size()) ? 32'(gnt_log[i]) : 32'hFFFF_FFFF, 32'(exp_rr[i]));

    // Backpressure from an empty pipeline.
    req_valid = '0;
    for (int i = 0; i < 3; i++) step(1);
    gnt_log.delete();
    resp_ready = 1'b0;
    req_valid  = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      randomize_ops();
      step(1);
    end
    check("bp_accepts", 32'(gnt_log.size()), 32'd2);
    check("bp_ready_low", 32'(req_ready), 32'd0);
    resp_ready = 1'b1;
    req_valid  = '0;
    for (int i = 0; i < 4; i++) step(1);

    // Sparse requesters 1 and 3 with the pointer parked at 2.
    do_reset();
    req_valid = 4'b0010;
    randomize_ops();
    step(1);
    gnt_log.delete();
    req_valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      randomize_ops();
      step(1);
    end
    for (int i = 0; i < 4; i++)
      check("sparse_grant_seq", (i < gnt_log.size()) ? 32'(gnt_log[i]) : 32'hFFFF_FFFF, 32'(exp_sp[i]));
    req_valid = '0;
    for (int i = 0; i < 3; i++) step(1);

    // Random traffic with random consumer stalls.
    for (int i = 0; i < 300; i++) begin
      req_valid  = NREQ'($urandom_range(0, 15));
      resp_ready = ($urandom_range(0, 3) != 0);
      randomize_ops();
      step(1);
    end
    resp_ready = 1'b1;
    req_valid  = '0;
    for (int i = 0; i < 3; i++) step(1);

    // Reset with both stages full.
    resp_ready = 1'b0;
    req_valid  = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      randomize_ops();
      step(1);
    end
    RST = 1'b1;
    step(1);
    RST        = 1'b0;
    req_valid  = '0;
    resp_ready = 1'b1;
    check("midrst_resp_valid", 32'(resp_valid), 32'd0);
    check("midrst_ops_count", 32'(ops_count), 32'd0);
    for (int i = 0; i < 3; i++) step(1);
    gnt_log.delete();
    req_valid = 4'b1111;
    step(1);
    check("midrst_first_grant", (gnt_log.size() > 0) ? 32'(gnt_log[0]) : 32'hFFFF_FFFF, 32'd0);
    req_valid = '0;
    for (int i = 0; i < 3; i++) step(1);

    // Completion counter wrap.
    do_reset();
    req_valid  = 4'b1111;
    resp_ready = 1'b1;
    guard      = 0;
    while (ops_m < 65535 && guard < 70000) begin
      step(0);
      guard++;
    end
    check("wrap_ffff", 32'(ops_count), 32'h0000_FFFF);
    while (ops_m < 65536 && guard < 70000) begin
      step(0);
      guard++;
    end
    check("wrap_zero", 32'(ops_count), 32'h0000_0000);
    req_valid = '0;
    for (int i = 0; i < 4; i++) step(1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
